// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the 5-stage MIPS pipeline.
//   CTRL_W           width of the decoded control word
//   CTRL_*           bit positions inside the control word, MSB first:
//                    {reg_write, mem_read, mem_write, mem_to_reg, alu_src,
//                     reg_dst, branch, alu_op[1:0]}
//   REG_ZERO         architectural $zero register index
package mips_pkg;

    localparam int unsigned CTRL_W         = 9;

    localparam int unsigned CTRL_REG_WRITE = 8;
    localparam int unsigned CTRL_MEM_READ  = 7;
    localparam int unsigned CTRL_MEM_WRITE = 6;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_ALU_SRC   = 4;
    localparam int unsigned CTRL_REG_DST   = 3;
    localparam int unsigned CTRL_BRANCH    = 2;
    localparam int unsigned CTRL_ALU_OP    = 0;  // LSB of the 2-bit alu_op field
    localparam int unsigned CTRL_ALU_OP_W  = 2;

    localparam logic [4:0]  REG_ZERO       = 5'd0;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
//   ex_valid, ex_mem_read, ex_rt   instruction currently held in ID/EX
//   id_rs, id_rt                   source fields of the instruction in IF/ID
//   id_uses_rs, id_uses_rt         whether IF/ID actually reads rs / rt
//   hz                             load in EX writes a register ID needs now
module load_use_detect
    import mips_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    output logic       hz
);

    logic match_rs;
    logic match_rt;

    always_comb begin
        match_rs = id_uses_rs && (ex_rt == id_rs);
        match_rt = id_uses_rt && (ex_rt == id_rt);
        // $zero is never really written, so a load to it cannot create a dependency.
        hz = ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && (match_rs || match_rt);
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion.
//   clk, rst_n              clock, asynchronous active-low reset
//   if_id_*                 decoded instruction fields, operands and control from ID
//   ctrl_in                 {reg_write, mem_read, mem_write, mem_to_reg, alu_src,
//                            reg_dst, branch, alu_op[1:0]}
//   flush                   squash the instruction entering EX
//   ext_stall               global freeze, all state holds
//   stall                   load-use stall, freezes PC and IF/ID
//   id_ex_*                 registered instruction presented to EX / forwarding
//   bubble_count            saturating count of inserted load-use bubbles
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        if_id_rs,
    input  logic [4:0]        if_id_rt,
    input  logic [4:0]        if_id_rd,
    input  logic              if_id_uses_rs,
    input  logic              if_id_uses_rt,
    input  logic [DATA_W-1:0] if_id_rdata1,
    input  logic [DATA_W-1:0] if_id_rdata2,
    input  logic [DATA_W-1:0] if_id_imm,
    input  logic [DATA_W-1:0] if_id_pc4,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              stall,
    output logic              id_ex_valid,
    output logic [4:0]        id_ex_rs,
    output logic [4:0]        id_ex_rt,
    output logic [4:0]        id_ex_rd,
    output logic [DATA_W-1:0] id_ex_rdata1,
    output logic [DATA_W-1:0] id_ex_rdata2,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [DATA_W-1:0] id_ex_pc4,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic [CNT_W-1:0]  bubble_count
);

    logic hz;

    load_use_detect u_detect (
        .ex_valid    (id_ex_valid),
        .ex_mem_read (id_ex_mem_read),
        .ex_rt       (id_ex_rt),
        .id_rs       (if_id_rs),
        .id_rt       (if_id_rt),
        .id_uses_rs  (if_id_uses_rs),
        .id_uses_rt  (if_id_uses_rt),
        .hz          (hz)
    );

    always_comb begin
        stall           = hz && !flush;
        id_ex_reg_write = id_ex_ctrl[CTRL_REG_WRITE];
        id_ex_mem_read  = id_ex_ctrl[CTRL_MEM_READ];
    end

    // Operand payload: meaningless whenever id_ex_valid is 0, so it simply
    // follows IF/ID on every edge that is not frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_rdata1 <= '0;
            id_ex_rdata2 <= '0;
            id_ex_imm    <= '0;
            id_ex_pc4    <= '0;
        end else if (flush || !ext_stall) begin
            id_ex_rdata1 <= if_id_rdata1;
            id_ex_rdata2 <= if_id_rdata2;
            id_ex_imm    <= if_id_imm;
            id_ex_pc4    <= if_id_pc4;
        end
    end

    // Validity, control, register fields and the bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid  <= 1'b0;
            id_ex_ctrl   <= '0;
            id_ex_rs     <= REG_ZERO;
            id_ex_rt     <= REG_ZERO;
            id_ex_rd     <= REG_ZERO;
            bubble_count <= '0;
        end else if (flush) begin
            id_ex_valid <= 1'b0;
            id_ex_ctrl  <= '0;
            id_ex_rs    <= if_id_rs;
            id_ex_rt    <= if_id_rt;
            id_ex_rd    <= if_id_rd;
        end else if (ext_stall) begin
            // Frozen: everything holds, including a pending hazard.
        end else if (hz) begin
            // Bubble: zeroed fields keep the forwarding unit from matching it.
            id_ex_valid <= 1'b0;
            id_ex_ctrl  <= '0;
            id_ex_rs    <= REG_ZERO;
            id_ex_rt    <= REG_ZERO;
            id_ex_rd    <= REG_ZERO;
            if (bubble_count != {CNT_W{1'b1}}) begin
                bubble_count <= bubble_count + 1'b1;
            end
        end else begin
            id_ex_valid <= 1'b1;
            id_ex_ctrl  <= ctrl_in;
            id_ex_rs    <= if_id_rs;
            id_ex_rt    <= if_id_rt;
            id_ex_rd    <= if_id_rd;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table, hand sequences and random stimulus for id_ex_stage.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_id_ex_stage;

    localparam logic [8:0] C_LW  = 9'h1B0;  // reg_write, mem_read, mem_to_reg, alu_src
    localparam logic [8:0] C_ADD = 9'h10A;  // reg_write, reg_dst, alu_op=10

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic        urs, urt;
        logic [31:0] d1, d2, imm, pc4;
        logic [8:0]  ctrl;
        logic        flush, ext;
    } in_t;

    typedef struct {
        in_t         in;
        logic        st;
        logic        vl;
        logic [8:0]  ctl;
        logic [4:0]  rt;
        logic        chk_rt;
        int          cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  if_id_rs = '0, if_id_rt = '0, if_id_rd = '0;
    logic        if_id_uses_rs = 1'b0, if_id_uses_rt = 1'b0;
    logic [31:0] if_id_rdata1 = '0, if_id_rdata2 = '0, if_id_imm = '0, if_id_pc4 = '0;
    logic [8:0]  ctrl_in = '0;
    logic        flush = 1'b0, ext_stall = 1'b0;

    logic        stall, id_ex_valid, id_ex_reg_write, id_ex_mem_read;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [31:0] id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_pc4;
    logic [8:0]  id_ex_ctrl;
    logic [15:0] bubble_count;

    logic        s_stall, s_valid, s_reg_write, s_mem_read;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc4;
    logic [8:0]  s_ctrl;
    logic [1:0]  s_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .if_id_rdata1(if_id_rdata1), .if_id_rdata2(if_id_rdata2),
        .if_id_imm(if_id_imm), .if_id_pc4(if_id_pc4), .ctrl_in(ctrl_in),
        .flush(flush), .ext_stall(ext_stall), .stall(stall), .id_ex_valid(id_ex_valid),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2),
        .id_ex_imm(id_ex_imm), .id_ex_pc4(id_ex_pc4), .id_ex_ctrl(id_ex_ctrl),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .bubble_count(bubble_count)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_rd(if_id_rd),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .if_id_rdata1(if_id_rdata1), .if_id_rdata2(if_id_rdata2),
        .if_id_imm(if_id_imm), .if_id_pc4(if_id_pc4), .ctrl_in(ctrl_in),
        .flush(flush), .ext_stall(ext_stall), .stall(s_stall), .id_ex_valid(s_valid),
        .id_ex_rs(s_rs), .id_ex_rt(s_rt), .id_ex_rd(s_rd),
        .id_ex_rdata1(s_rdata1), .id_ex_rdata2(s_rdata2),
        .id_ex_imm(s_imm), .id_ex_pc4(s_pc4), .id_ex_ctrl(s_ctrl),
        .id_ex_reg_write(s_reg_write), .id_ex_mem_read(s_mem_read),
        .bubble_count(s_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic urs, input logic urt, input logic [8:0] ctrl,
                               input logic fl, input logic ex);
        in_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.urs = urs; v.urt = urt;
        v.d1 = $urandom; v.d2 = $urandom; v.imm = $urandom; v.pc4 = $urandom;
        v.ctrl = ctrl; v.flush = fl; v.ext = ex;
        return v;
    endfunction

    function automatic vec_t mv(input in_t in, input logic st, input logic vl,
                                input logic [8:0] ctl, input logic [4:0] rt,
                                input logic chk_rt, input int cnt);
        vec_t v;
        v.in = in; v.st = st; v.vl = vl; v.ctl = ctl; v.rt = rt; v.chk_rt = chk_rt;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic apply(input in_t v);
        if_id_rs = v.rs; if_id_rt = v.rt; if_id_rd = v.rd;
        if_id_uses_rs = v.urs; if_id_uses_rt = v.urt;
        if_id_rdata1 = v.d1; if_id_rdata2 = v.d2; if_id_imm = v.imm; if_id_pc4 = v.pc4;
        ctrl_in = v.ctrl; flush = v.flush; ext_stall = v.ext;
    endtask

    task automatic drive_cycle(input in_t v);
        apply(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'h0, 1'b0, 1'b0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[17];

    // Reference model state: the instruction sitting in EX.
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_d1, m_d2, m_imm, m_pc4;
    logic        m_known;
    int          m_cnt;

    function automatic logic model_hz(input in_t v);
        logic needs;
        needs = (v.urs && v.rs == m_rt) || (v.urt && v.rt == m_rt);
        return m_valid && m_ctrl[7] && (m_rt != 5'd0) && needs;
    endfunction

    initial begin
        in_t  lw8, add98, lw88, lw6, use6, cur;
        logic exp_st;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        #2;
        chk("rst_valid", 64'(id_ex_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_count", 64'(bubble_count), 64'd0);
        chk("rst_ctrl", 64'(id_ex_ctrl), 64'd0);
        do_reset();

        // ---------------- directed table ----------------
        lw8   = mk(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, C_LW, 1'b0, 1'b0);
        add98 = mk(5'd8, 5'd10, 5'd9, 1'b1, 1'b1, C_ADD, 1'b0, 1'b0);
        lw88  = mk(5'd8, 5'd8, 5'd0, 1'b1, 1'b0, C_LW, 1'b0, 1'b0);
        lw6   = mk(5'd2, 5'd6, 5'd0, 1'b1, 1'b0, C_LW, 1'b0, 1'b0);
        use6  = mk(5'd6, 5'd1, 5'd7, 1'b1, 1'b1, C_ADD, 1'b0, 1'b1);
        tbl[0]  = mv(lw8,   1'b0, 1'b1, C_LW,  5'd8,  1'b1, 0);
        tbl[1]  = mv(add98, 1'b1, 1'b0, 9'h0,  5'd0,  1'b1, 1);
        tbl[2]  = mv(add98, 1'b0, 1'b1, C_ADD, 5'd10, 1'b1, 1);
        tbl[3]  = mv(lw8,   1'b0, 1'b1, C_LW,  5'd8,  1'b1, 1);
        tbl[4]  = mv(lw88,  1'b1, 1'b0, 9'h0,  5'd0,  1'b1, 2);
        tbl[5]  = mv(lw88,  1'b0, 1'b1, C_LW,  5'd8,  1'b1, 2);
        tbl[6]  = mv(mk(5'd3, 5'd8, 5'd4, 1'b1, 1'b0, C_ADD, 1'b0, 1'b0),
                     1'b0, 1'b1, C_ADD, 5'd8, 1'b1, 2);
        tbl[7]  = mv(mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW, 1'b0, 1'b0),
                     1'b0, 1'b1, C_LW, 5'd0, 1'b1, 2);
        tbl[8]  = mv(mk(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, C_ADD, 1'b0, 1'b0),
                     1'b0, 1'b1, C_ADD, 5'd0, 1'b1, 2);
        tbl[9]  = mv(mk(5'd1, 5'd5, 5'd0, 1'b1, 1'b0, C_LW, 1'b0, 1'b0),
                     1'b0, 1'b1, C_LW, 5'd5, 1'b1, 2);
        tbl[10] = mv(mk(5'd5, 5'd5, 5'd2, 1'b1, 1'b1, C_ADD, 1'b1, 1'b0),
                     1'b0, 1'b0, 9'h0, 5'd0, 1'b0, 2);
        tbl[11] = mv(lw6,   1'b0, 1'b1, C_LW,  5'd6,  1'b1, 2);
        tbl[12] = mv(use6,  1'b1, 1'b1, C_LW,  5'd6,  1'b1, 2);
        tbl[13] = mv(use6,  1'b1, 1'b1, C_LW,  5'd6,  1'b1, 2);
        tbl[14] = mv(use6,  1'b1, 1'b1, C_LW,  5'd6,  1'b1, 2);
        use6.ext = 1'b0;
        tbl[15] = mv(use6,  1'b1, 1'b0, 9'h0,  5'd0,  1'b1, 3);
        tbl[16] = mv(use6,  1'b0, 1'b1, C_ADD, 5'd1,  1'b1, 3);

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].in);
            #1;
            chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].st));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 64'(id_ex_valid), 64'(tbl[i].vl));
            chk($sformatf("tbl%0d_ctrl", i), 64'(id_ex_ctrl), 64'(tbl[i].ctl));
            if (tbl[i].chk_rt) chk($sformatf("tbl%0d_rt", i), 64'(id_ex_rt), 64'(tbl[i].rt));
            chk($sformatf("tbl%0d_count", i), 64'(bubble_count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_count2", i), 64'(s_count), 64'(sat(tbl[i].cnt, 3)));
        end

        // ---------------- counter saturation: 5 load-use pairs ----------------
        do_reset();
        for (int p = 0; p < 5; p++) begin
            drive_cycle(mk(5'd1, 5'd4, 5'd0, 1'b1, 1'b0, C_LW, 1'b0, 1'b0));
            cur = mk(5'd4, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD, 1'b0, 1'b0);
            drive_cycle(cur);
            drive_cycle(cur);
        end
        chk("sat_count16", 64'(bubble_count), 64'd5);
        chk("sat_count2", 64'(s_count), 64'd3);

        // ---------------- reset mid-cycle with a hazard pending ----------------
        drive_cycle(mk(5'd1, 5'd9, 5'd0, 1'b1, 1'b0, C_LW, 1'b0, 1'b0));
        apply(mk(5'd9, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD, 1'b0, 1'b0));
        #1;
        chk("pre_rst_stall", 64'(stall), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_valid", 64'(id_ex_valid), 64'd0);
        chk("mid_rst_ctrl", 64'(id_ex_ctrl), 64'd0);
        chk("mid_rst_rt", 64'(id_ex_rt), 64'd0);
        chk("mid_rst_pc4", 64'(id_ex_pc4), 64'd0);
        chk("mid_rst_count", 64'(bubble_count), 64'd0);
        chk("mid_rst_count2", 64'(s_count), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 64'(id_ex_valid), 64'd0);
        chk("rst_hold_count", 64'(bubble_count), 64'd0);

        // ---------------- random stimulus against the model ----------------
        do_reset();
        m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc4 = '0; m_known = 1'b1; m_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            logic [8:0] c;
            c = 9'($urandom);
            if ($urandom_range(0, 1) == 0) c[7] = 1'b1;
            cur = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                     1'($urandom), 1'($urandom), c,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            apply(cur);
            #1;
            exp_st = model_hz(cur) && !cur.flush;
            chk("rnd_stall", 64'(stall), 64'(exp_st));
            chk("rnd_stall2", 64'(s_stall), 64'(exp_st));
            @(posedge clk);
            if (cur.flush) begin
                m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
            end else if (cur.ext) begin
                // frozen
            end else if (model_hz(cur)) begin
                m_valid = 1'b0; m_ctrl = '0;
                m_rs = '0; m_rt = '0; m_rd = '0; m_known = 1'b1;
                m_cnt++;
            end else begin
                m_valid = 1'b1; m_ctrl = cur.ctrl;
                m_rs = cur.rs; m_rt = cur.rt; m_rd = cur.rd; m_known = 1'b1;
                m_d1 = cur.d1; m_d2 = cur.d2; m_imm = cur.imm; m_pc4 = cur.pc4;
            end
            // A flushed slot's fields are unspecified; track them for hazard
            // purposes only through valid=0, which masks them anyway.
            if (!m_known) begin
                m_rs = cur.rs; m_rt = cur.rt; m_rd = cur.rd;
            end
            #1;
            chk("rnd_valid", 64'(id_ex_valid), 64'(m_valid));
            chk("rnd_ctrl", 64'(id_ex_ctrl), 64'(m_ctrl));
            chk("rnd_regwr", 64'(id_ex_reg_write), 64'(m_ctrl[8]));
            chk("rnd_memrd", 64'(id_ex_mem_read), 64'(m_ctrl[7]));
            chk("rnd_count", 64'(bubble_count), 64'(m_cnt));
            chk("rnd_count2", 64'(s_count), 64'(sat(m_cnt, 3)));
            if (m_known) begin
                chk("rnd_rs", 64'(id_ex_rs), 64'(m_rs));
                chk("rnd_rt", 64'(id_ex_rt), 64'(m_rt));
                chk("rnd_rd", 64'(id_ex_rd), 64'(m_rd));
            end
            if (m_valid) begin
                chk("rnd_d1", 64'(id_ex_rdata1), 64'(m_d1));
                chk("rnd_d2", 64'(id_ex_rdata2), 64'(m_d2));
                chk("rnd_imm", 64'(id_ex_imm), 64'(m_imm));
                chk("rnd_pc4", 64'(id_ex_pc4), 64'(m_pc4));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
